// File: rtl/bless_local_ni.sv
// Local network interface for a bufferless BLESS router port: an injection FIFO feeding
// dinLocal when the router grants a slot, and an ejection FIFO capturing doutLocal.
`ifndef WIDTH_PORT
`define WIDTH_PORT 32
`endif

module bless_local_ni #(
    parameter int FLIT_W    = `WIDTH_PORT,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inj_valid,
    output logic              inj_ready,
    input  logic [FLIT_W-1:0] inj_data,
    input  logic              inject_ok,
    output logic [FLIT_W-1:0] dinLocal,
    input  logic [FLIT_W-1:0] doutLocal,
    output logic              ej_valid,
    input  logic              ej_ready,
    output logic [FLIT_W-1:0] ej_data,
    output logic              ej_overflow,
    output logic [7:0]        drop_cnt
);

    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int EAW = $clog2(EJ_DEPTH);
    localparam logic [IAW:0] INJ_ONE = 1;
    localparam logic [EAW:0] EJ_ONE  = 1;

    logic [FLIT_W-1:0] r_inj_mem [INJ_DEPTH];
    logic [FLIT_W-1:0] r_ej_mem  [EJ_DEPTH];
    logic [IAW:0]      r_inj_wp, r_inj_rp;
    logic [EAW:0]      r_ej_wp, r_ej_rp;
    logic [FLIT_W-1:0] r_din;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic w_inj_full, w_inj_empty, w_inj_push, w_inj_pop;
    logic w_ej_full, w_ej_empty, w_ej_push, w_ej_pop, w_ej_drop;
    logic w_dout_present;

    assign w_inj_full  = (r_inj_wp[IAW] != r_inj_rp[IAW]) &&
                         (r_inj_wp[IAW-1:0] == r_inj_rp[IAW-1:0]);
    assign w_inj_empty = (r_inj_wp == r_inj_rp);
    assign inj_ready   = !w_inj_full && !reset;
    // Zero flits are bubbles: the handshake completes but nothing is stored.
    assign w_inj_push  = inj_valid && inj_ready && (inj_data != '0);
    assign w_inj_pop   = inject_ok && !w_inj_empty;

    assign w_ej_full      = (r_ej_wp[EAW] != r_ej_rp[EAW]) &&
                            (r_ej_wp[EAW-1:0] == r_ej_rp[EAW-1:0]);
    assign w_ej_empty     = (r_ej_wp == r_ej_rp);
    assign w_ej_pop       = !w_ej_empty && ej_ready;
    assign w_dout_present = (doutLocal != '0);
    // The router cannot be stalled, so a full FIFO only accepts if its head leaves this cycle.
    assign w_ej_push      = w_dout_present && (!w_ej_full || w_ej_pop);
    assign w_ej_drop      = w_dout_present && !w_ej_push;

    assign ej_valid    = !w_ej_empty;
    assign ej_data     = w_ej_empty ? '0 : r_ej_mem[r_ej_rp[EAW-1:0]];
    assign dinLocal    = r_din;
    assign ej_overflow = r_overflow;
    assign drop_cnt    = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (w_inj_push) r_inj_mem[r_inj_wp[IAW-1:0]] <= inj_data;
        if (w_ej_push)  r_ej_mem[r_ej_wp[EAW-1:0]]   <= doutLocal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inj_wp <= '0;
            r_inj_rp <= '0;
            r_din    <= '0;
        end else begin
            if (w_inj_push) r_inj_wp <= r_inj_wp + INJ_ONE;
            if (w_inj_pop) begin
                r_din    <= r_inj_mem[r_inj_rp[IAW-1:0]];
                r_inj_rp <= r_inj_rp + INJ_ONE;
            end else begin
                r_din    <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ej_wp    <= '0;
            r_ej_rp    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_ej_push) r_ej_wp <= r_ej_wp + EJ_ONE;
            if (w_ej_pop)  r_ej_rp <= r_ej_rp + EJ_ONE;
            if (w_ej_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bless_local_ni.sv
// Bench for bless_local_ni: directed scenarios with constant expectations, then randomized
// traffic checked against a queue-based model of the two FIFOs and the drop counter.
module tb_bless_local_ni;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         inj_valid;
    logic         inj_ready;
    logic [W-1:0] inj_data;
    logic         inject_ok;
    logic [W-1:0] dinLocal;
    logic [W-1:0] doutLocal;
    logic         ej_valid;
    logic         ej_ready;
    logic [W-1:0] ej_data;
    logic         ej_overflow;
    logic [7:0]   drop_cnt;

    int total = 0;
    int bad   = 0;

    bless_local_ni #(.FLIT_W(W), .INJ_DEPTH(D), .EJ_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_data(inj_data),
        .inject_ok(inject_ok), .dinLocal(dinLocal), .doutLocal(doutLocal),
        .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_data(ej_data),
        .ej_overflow(ej_overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; inj_valid = 1'b0; inj_data = '0; inject_ok = 1'b0;
        doutLocal = '0; ej_ready = 1'b0;
        tick(); tick();
        total++; if (dinLocal !== '0)    begin bad++; $display("FAIL rst_din got=%h exp=0", dinLocal); end
        total++; if (inj_ready !== 1'b0) begin bad++; $display("FAIL rst_inj_ready got=%b exp=0", inj_ready); end
        total++; if (ej_valid !== 1'b0)  begin bad++; $display("FAIL rst_ej_valid got=%b exp=0", ej_valid); end
        total++; if (ej_data !== '0)     begin bad++; $display("FAIL rst_ej_data got=%h exp=0", ej_data); end
        total++; if (ej_overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ej_overflow); end
        total++; if (drop_cnt !== 8'd0)  begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
        reset = 1'b0;
        #1;
        total++; if (inj_ready !== 1'b1) begin bad++; $display("FAIL rel_inj_ready got=%b exp=1", inj_ready); end
    endtask

    task automatic test_inject_basic();
        inject_ok = 1'b1;
        inj_valid = 1'b1; inj_data = 16'h0011;
        tick();
        total++; if (dinLocal !== '0) begin bad++; $display("FAIL inj_lat got=%h exp=0", dinLocal); end
        inj_data = 16'h0022;
        tick();
        total++; if (dinLocal !== 16'h0011) begin bad++; $display("FAIL inj_a got=%h exp=0011", dinLocal); end
        total++; if (inj_ready !== 1'b1) begin bad++; $display("FAIL inj_ready_a got=%b exp=1", inj_ready); end
        inj_valid = 1'b0; inj_data = '0;
        tick();
        total++; if (dinLocal !== 16'h0022) begin bad++; $display("FAIL inj_b got=%h exp=0022", dinLocal); end
        tick();
        total++; if (dinLocal !== '0) begin bad++; $display("FAIL inj_idle got=%h exp=0", dinLocal); end
        total++; if (inj_ready !== 1'b1) begin bad++; $display("FAIL inj_ready_b got=%b exp=1", inj_ready); end
    endtask

    task automatic test_inject_backpressure();
        logic [W-1:0] exp;
        inject_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (inj_ready !== 1'b1) begin bad++; $display("FAIL bp_ready%0d got=%b exp=1", i, inj_ready); end
            inj_valid = 1'b1; inj_data = W'(16'h0031 + i);
            tick();
            total++; if (dinLocal !== '0) begin bad++; $display("FAIL bp_hold%0d got=%h exp=0", i, dinLocal); end
        end
        total++; if (inj_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", inj_ready); end
        inj_data = 16'h0035;
        tick();
        total++; if (inj_ready !== 1'b0) begin bad++; $display("FAIL bp_full2 got=%b exp=0", inj_ready); end
        inj_valid = 1'b0; inj_data = '0; inject_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = W'(16'h0031 + i);
            total++; if (dinLocal !== exp) begin bad++; $display("FAIL bp_out%0d got=%h exp=%h", i, dinLocal, exp); end
            total++; if (inj_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after%0d got=%b exp=1", i, inj_ready); end
        end
        tick();
        total++; if (dinLocal !== '0) begin bad++; $display("FAIL bp_no5th got=%h exp=0", dinLocal); end
    endtask

    task automatic test_bubble();
        inject_ok = 1'b1; inj_valid = 1'b1; inj_data = '0;
        total++; if (inj_ready !== 1'b1) begin bad++; $display("FAIL bub_ready got=%b exp=1", inj_ready); end
        tick();
        inj_valid = 1'b0;
        total++; if (dinLocal !== '0) begin bad++; $display("FAIL bub_din0 got=%h exp=0", dinLocal); end
        tick();
        total++; if (dinLocal !== '0) begin bad++; $display("FAIL bub_din1 got=%h exp=0", dinLocal); end
    endtask

    task automatic test_eject_overflow();
        logic [W-1:0] exp;
        ej_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            doutLocal = W'(16'h0041 + i);
            tick();
            total++; if (ej_data !== 16'h0041) begin bad++; $display("FAIL ej_head%0d got=%h exp=0041", i, ej_data); end
        end
        doutLocal = '0;
        total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ej_drop got=%0d exp=2", drop_cnt); end
        total++; if (ej_overflow !== 1'b1) begin bad++; $display("FAIL ej_ovf got=%b exp=1", ej_overflow); end
        ej_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = W'(16'h0041 + i);
            total++; if (ej_valid !== 1'b1 || ej_data !== exp) begin
                bad++; $display("FAIL ej_drain%0d got=%b/%h exp=1/%h", i, ej_valid, ej_data, exp); end
            tick();
        end
        total++; if (ej_valid !== 1'b0 || ej_data !== '0) begin
            bad++; $display("FAIL ej_empty got=%b/%h exp=0/0", ej_valid, ej_data); end
        tick();
        total++; if (ej_valid !== 1'b0) begin bad++; $display("FAIL ej_rdy_empty got=%b exp=0", ej_valid); end
        ej_ready = 1'b0;
    endtask

    task automatic test_eject_full_pop();
        logic [W-1:0] exp;
        ej_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            doutLocal = W'(16'h0051 + i);
            tick();
        end
        doutLocal = 16'h0055; ej_ready = 1'b1;
        tick();
        doutLocal = '0; ej_ready = 1'b0;
        total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL fp_drop got=%0d exp=2", drop_cnt); end
        ej_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = W'(16'h0052 + i);
            total++; if (ej_valid !== 1'b1 || ej_data !== exp) begin
                bad++; $display("FAIL fp_drain%0d got=%b/%h exp=1/%h", i, ej_valid, ej_data, exp); end
            tick();
        end
        total++; if (ej_valid !== 1'b0) begin bad++; $display("FAIL fp_empty got=%b exp=0", ej_valid); end
        ej_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        inject_ok = 1'b0; inj_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            inj_data = W'(16'h0061 + i);
            doutLocal = W'(16'h0071 + i);
            tick();
        end
        inj_valid = 1'b0; inj_data = '0; doutLocal = '0;
        #2 reset = 1'b1;
        #1;
        total++; if (dinLocal !== '0 || inj_ready !== 1'b0) begin
            bad++; $display("FAIL mid_inj got=%h/%b exp=0/0", dinLocal, inj_ready); end
        total++; if (ej_valid !== 1'b0 || ej_data !== '0) begin
            bad++; $display("FAIL mid_ej got=%b/%h exp=0/0", ej_valid, ej_data); end
        total++; if (ej_overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++; $display("FAIL mid_drop got=%b/%0d exp=0/0", ej_overflow, drop_cnt); end
        tick();
        reset = 1'b0;
        inject_ok = 1'b1; inj_valid = 1'b1; inj_data = 16'h0077;
        tick();
        inj_valid = 1'b0; inj_data = '0;
        total++; if (dinLocal !== '0) begin bad++; $display("FAIL mid_lat got=%h exp=0", dinLocal); end
        tick();
        total++; if (dinLocal !== 16'h0077) begin bad++; $display("FAIL mid_new got=%h exp=0077", dinLocal); end
        tick();
        total++; if (dinLocal !== '0) begin bad++; $display("FAIL mid_noreplay got=%h exp=0", dinLocal); end
    endtask

    task automatic test_random();
        logic [W-1:0] mq_inj[$];
        logic [W-1:0] mq_ej[$];
        int           m_drop = 0;
        logic         m_ovf  = 1'b0;
        logic [W-1:0] exp_din, exp_head;
        logic         exp_rdy, ej_pop;
        int           errs = 0;
        for (int c = 0; c < 500; c++) begin
            inj_valid = ($urandom_range(0, 1) == 1);
            inj_data  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 16'hFFFF));
            inject_ok = ($urandom_range(0, 9) < 6);
            doutLocal = ($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 16'hFFFF)) : '0;
            ej_ready  = ($urandom_range(0, 9) < 4);
            #1;
            exp_rdy  = (mq_inj.size() < D);
            exp_head = (mq_ej.size() > 0) ? mq_ej[0] : '0;
            total++;
            if (inj_ready !== exp_rdy || ej_valid !== (mq_ej.size() > 0) || ej_data !== exp_head) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rnd_pre c=%0d rdy=%b/%b ej=%b/%h exp_ej=%0d/%h",
                                        c, inj_ready, exp_rdy, ej_valid, ej_data, mq_ej.size() > 0, exp_head);
            end
            exp_din = '0;
            if (inject_ok && mq_inj.size() > 0) exp_din = mq_inj.pop_front();
            if (inj_valid && exp_rdy && inj_data != '0) mq_inj.push_back(inj_data);
            ej_pop = ej_ready && mq_ej.size() > 0;
            if (ej_pop) void'(mq_ej.pop_front());
            if (doutLocal != '0) begin
                if (mq_ej.size() < D) mq_ej.push_back(doutLocal);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            tick();
            total++;
            if (dinLocal !== exp_din || drop_cnt !== 8'(m_drop) || ej_overflow !== m_ovf) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rnd_post c=%0d din=%h/%h drop=%0d/%0d ovf=%b/%b",
                                        c, dinLocal, exp_din, drop_cnt, m_drop, ej_overflow, m_ovf);
            end
        end
        inj_valid = 1'b0; inj_data = '0; doutLocal = '0; ej_ready = 1'b0;
    endtask

    task automatic test_drop_saturate();
        ej_ready = 1'b0;
        for (int i = 0; i < 270; i++) begin
            doutLocal = W'(16'h0100 + i);
            tick();
        end
        doutLocal = '0;
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_drop got=%0d exp=255", drop_cnt); end
        total++; if (ej_overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", ej_overflow); end
    endtask

    initial begin
        test_reset();
        test_inject_basic();
        test_inject_backpressure();
        test_bubble();
        test_eject_overflow();
        test_eject_full_pop();
        test_reset_mid();
        test_random();
        test_drop_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
